// File: rtl/delay_line_probe.sv
// delay_line_probe: measures the cycle latency of an external registered delay line.
// Define DELAY_LINE_PROBE_MINMAX_EN to add min/max latency statistics and stats_clr.
module delay_line_probe #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter int FLUSH_CYC = 128,
    parameter int MAX_WAIT  = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    output logic [DATA_W-1:0] tx_data,
    input  logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  latency
`ifdef DELAY_LINE_PROBE_MINMAX_EN
    ,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  min_latency,
    output logic [CNT_W-1:0]  max_latency
`endif
);
    typedef enum logic [1:0] {IDLE, FLUSH, WAIT} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, latency_n;
    logic [DATA_W-1:0] pattern_q, pattern_n, tx_n;
    logic busy_n, done_n, timeout_n;
    logic flush_end, match, expired;
    assign flush_end = cnt == CNT_W'(FLUSH_CYC - 1);
    assign match     = rx_data == pattern_q;
    assign expired   = cnt == CNT_W'(MAX_WAIT);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end
    always_comb begin
        state_n = (state == IDLE  && start)              ? FLUSH :
                  (state == FLUSH && flush_end)          ? WAIT  :
                  (state == WAIT  && (match || expired)) ? IDLE  : state;
    end
    // Match is tested before expiry so a word arriving on the last count still counts.
    always_comb begin
        tx_n      = tx_data;
        cnt_n     = cnt;
        pattern_n = pattern_q;
        busy_n    = busy;
        done_n    = done;
        timeout_n = timeout;
        latency_n = latency;
        case (state)
            IDLE: if (start) begin
                pattern_n = pattern;
                tx_n      = ~pattern;
                cnt_n     = '0;
                done_n    = 1'b0;
                timeout_n = 1'b0;
                busy_n    = 1'b1;
            end
            FLUSH: begin
                tx_n  = flush_end ? pattern_q : ~pattern_q;
                cnt_n = flush_end ? '0 : cnt + CNT_W'(1);
            end
            WAIT: begin
                tx_n = ~pattern_q;
                if (match) begin
                    latency_n = cnt;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    tx_n      = '0;
                end else if (expired) begin
                    latency_n = CNT_W'(MAX_WAIT);
                    timeout_n = 1'b1;
                    busy_n    = 1'b0;
                    tx_n      = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_data   <= '0;
            cnt       <= '0;
            pattern_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            latency   <= '0;
        end else begin
            tx_data   <= tx_n;
            cnt       <= cnt_n;
            pattern_q <= pattern_n;
            busy      <= busy_n;
            done      <= done_n;
            timeout   <= timeout_n;
            latency   <= latency_n;
        end
    end
`ifdef DELAY_LINE_PROBE_MINMAX_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || stats_clr) begin
            min_latency <= '1;
            max_latency <= '0;
        end else if (state == WAIT && match) begin
            min_latency <= (cnt < min_latency) ? cnt : min_latency;
            max_latency <= (cnt > max_latency) ? cnt : max_latency;
        end
    end
`endif
endmodule

// File: tb/tb_delay_line_probe.sv
// tb_delay_line_probe: directed bench driving delay_line_probe through a tapped shift line.
// Statistics checks are compiled in when DELAY_LINE_PROBE_MINMAX_EN is defined.
module tb_delay_line_probe;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [7:0] tx_data, rx_data;
    logic       busy, done, timeout;
    logic [7:0] latency;
    logic       stats_clr = 1'b0;
    logic [7:0] min_latency, max_latency;
    logic [7:0] line [1:90];
    int         taps = 0;
    logic       tie = 1'b0;
    int         checks = 0;
    int         passed = 0;
    int         cyc;

    delay_line_probe dut (
        .clock(clock), .reset_n(reset_n), .start(start), .pattern(pattern),
        .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
        .timeout(timeout), .latency(latency)
`ifdef DELAY_LINE_PROBE_MINMAX_EN
        , .stats_clr(stats_clr), .min_latency(min_latency), .max_latency(max_latency)
`endif
    );
`ifndef DELAY_LINE_PROBE_MINMAX_EN
    assign min_latency = 8'hFF;
    assign max_latency = 8'h00;
`endif

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        line[1] <= tx_data;
        for (int i = 2; i <= 90; i++) line[i] <= line[i-1];
    end
    always_comb rx_data = tie ? 8'h00 : (taps == 0) ? tx_data : line[taps];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run(input int n_taps, input logic [7:0] pat, output int n);
        taps = n_taps;
        @(negedge clock);
        pattern = pat;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(n);
    endtask

    task automatic chk_done(input string name, input logic [7:0] lat);
        chk({name, "_done"}, done, 1);
        chk({name, "_timeout"}, timeout, 0);
        chk({name, "_latency"}, latency, lat);
        chk({name, "_tx"}, tx_data, 0);
    endtask

    initial begin
        #1;
        chk("rst_tx", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_latency", latency, 0);
        @(negedge clock);
        reset_n = 1'b1;
        // loopback: busy spans FLUSH_CYC+1 cycles
        run(0, 8'hA5, cyc);
        chk("loop_busy_cycles", cyc, 129);
        chk_done("loop", 8'd0);
        run(30, 8'h3C, cyc);
        chk_done("tap30", 8'd30);
        run(45, 8'h3C, cyc);
        chk_done("tap45", 8'd45);
        run(60, 8'h3C, cyc);
        chk_done("tap60", 8'd60);
        run(90, 8'h3C, cyc);
        chk_done("tap90", 8'd90);
        // stuck-at-zero line never returns 0xFF
        tie = 1'b1;
        run(0, 8'hFF, cyc);
        tie = 1'b0;
        chk("to_busy_cycles", cyc, 384);
        chk("to_timeout", timeout, 1);
        chk("to_done", done, 0);
        chk("to_latency", latency, 255);
        chk("to_tx", tx_data, 0);
        // start mid-WAIT is ignored
        taps = 90;
        @(negedge clock);
        pattern = 8'h3C;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (140) @(negedge clock);
        pattern = 8'h11;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("ign_busy", busy, 1);
        wait_idle(cyc);
        chk_done("ign", 8'd90);
        // asynchronous reset mid-WAIT
        @(negedge clock);
        pattern = 8'h3C;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (150) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_tx", tx_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_latency", latency, 0);
        @(negedge clock);
        reset_n = 1'b1;
        run(90, 8'h3C, cyc);
        chk_done("post_rst", 8'd90);
        run(60, 8'h00, cyc);
        chk_done("pat00", 8'd60);
        // held start retriggers and clears done on that edge
        taps = 0;
        @(negedge clock);
        pattern = 8'h5A;
        start = 1'b1;
        @(negedge clock);
        wait_idle(cyc);
        chk("held_done", done, 1);
        @(negedge clock);
        chk("retrig_busy", busy, 1);
        chk("retrig_done", done, 0);
        start = 1'b0;
        wait_idle(cyc);
        chk_done("retrig", 8'd0);
`ifdef DELAY_LINE_PROBE_MINMAX_EN
        @(negedge clock);
        stats_clr = 1'b1;
        @(negedge clock);
        stats_clr = 1'b0;
        chk("clr_min", min_latency, 8'hFF);
        chk("clr_max", max_latency, 8'h00);
        run(30, 8'h3C, cyc);
        run(90, 8'h3C, cyc);
        run(45, 8'h3C, cyc);
        chk("mm_min", min_latency, 30);
        chk("mm_max", max_latency, 90);
        tie = 1'b1;
        run(0, 8'hFF, cyc);
        tie = 1'b0;
        chk("mm_to_min", min_latency, 30);
        chk("mm_to_max", max_latency, 90);
        @(negedge clock);
        stats_clr = 1'b1;
        @(negedge clock);
        stats_clr = 1'b0;
        chk("clr2_min", min_latency, 8'hFF);
        chk("clr2_max", max_latency, 8'h00);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
